// File: rtl/bus_arbiter_nch.sv
// N-client arbiter in front of a single server port: strict-priority or round-robin
// selection, registered grant index and a server-ack watchdog.
module bus_arbiter_nch #(
    parameter int                               DATA_WIDTH  = 8,
    parameter int                               ADDR_WIDTH  = 4,
    parameter int                               NUM_CLIENTS = 4,
    parameter int                               PRIO_W      = 4,
    parameter logic [NUM_CLIENTS*PRIO_W-1:0]    CLIENT_PRIO = {4'd0, 4'd1, 4'd2, 4'd3},
    parameter logic                             SCHED_MODE  = 1'b0,
    parameter int                               TIMEOUT     = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            client_rq,
    input  logic [NUM_CLIENTS-1:0]            client_wr_ni,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataW,
    output logic [NUM_CLIENTS-1:0]            client_ack,
    output logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataR,
    output logic                              server_rq,
    output logic                              server_wr_ni,
    output logic [ADDR_WIDTH-1:0]             server_address,
    output logic [DATA_WIDTH-1:0]             server_dataW,
    input  logic                              server_ack,
    input  logic [DATA_WIDTH-1:0]             server_dataR,
    output logic [3:0]                        grant_id,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int                     CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
    localparam logic [NUM_CLIENTS-1:0] ONE      = NUM_CLIENTS'(1);

    // state | meaning
    // IDLE  | waiting for any client request
    // GRANT | server port driven by the granted client, waiting for ack or watchdog
    // DONE  | one dead cycle so the served client can drop its request
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        grant_q;
    logic [3:0]        rr_q;
    logic [3:0]        winner;
    logic [CNT_W-1:0]  count;
    logic              found;
    logic [PRIO_W-1:0] best_prio;
    int                idx;
    logic              expire;
    logic              finish;

    // The table literal lists clients 0..N-1 from left to right, so client i lives
    // in the i-th field counted from the MSB end.
    function automatic logic [PRIO_W-1:0] prio_of(input int i);
        return CLIENT_PRIO[(NUM_CLIENTS-1-i)*PRIO_W +: PRIO_W];
    endfunction

    always_comb begin
        winner    = 4'd0;
        found     = 1'b0;
        best_prio = '0;
        idx       = 0;
        if (SCHED_MODE) begin
            for (int k = 1; k <= NUM_CLIENTS; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
                if (!found && (|(client_rq & (ONE << idx)))) begin
                    found  = 1'b1;
                    winner = 4'(idx);
                end
            end
        end else begin
            // strict '>' keeps the lowest index on equal priority
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if ((|(client_rq & (ONE << i))) && (!found || prio_of(i) > best_prio)) begin
                    found     = 1'b1;
                    best_prio = prio_of(i);
                    winner    = 4'(i);
                end
            end
        end
    end

    assign expire = (TIMEOUT != 0) && (count == CNT_LAST);
    assign finish = (state == GRANT) && (server_ack || expire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|client_rq) state_nxt = GRANT;
            GRANT:   if (server_ack || expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q <= 4'd0;
            rr_q    <= 4'(NUM_CLIENTS - 1);
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (|client_rq) grant_q <= winner;
                end
                GRANT: begin
                    if (finish) begin
                        count <= '0;
                        rr_q  <= grant_q;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    grant_q <= 4'd0;
                    count   <= '0;
                end
                default: count <= '0;
            endcase
        end
    end

    always_comb begin
        busy           = 1'b0;
        server_rq      = 1'b0;
        server_wr_ni   = 1'b0;
        server_address = '0;
        server_dataW   = '0;
        client_ack     = '0;
        client_dataR   = '0;
        timeout_err    = 1'b0;
        if (state == GRANT) begin
            busy           = 1'b1;
            server_rq      = 1'b1;
            server_wr_ni   = |(client_wr_ni & (ONE << grant_q));
            server_address = client_address[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
            server_dataW   = client_dataW[grant_q*DATA_WIDTH +: DATA_WIDTH];
            if (server_ack) begin
                client_ack = ONE << grant_q;
                client_dataR[grant_q*DATA_WIDTH +: DATA_WIDTH] = server_dataR;
            end else if (expire) begin
                client_ack  = ONE << grant_q;
                timeout_err = 1'b1;
            end
        end
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_bus_arbiter_nch.sv
// Bench for bus_arbiter_nch: three instances (strict, round robin, short watchdog)
// on a shared client bus, directed scenarios plus randomized transactions.
module tb_bus_arbiter_nch;
    localparam int NC = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset = 1'b0;
    logic [NC-1:0]        client_rq = '0;
    logic [NC-1:0]        client_wr_ni = '0;
    logic [NC*AW-1:0]     client_address = '0;
    logic [NC*DW-1:0]     client_dataW = '0;
    logic [2:0][NC-1:0]   c_ack;
    logic [2:0][NC*DW-1:0] c_dr;
    logic [2:0]           s_rq, s_wr, bsy, terr, s_ack;
    logic [2:0][AW-1:0]   s_addr;
    logic [2:0][DW-1:0]   s_dw, s_dr;
    logic [2:0][3:0]      gid;
    logic [2:0]           auto_ack = '0;
    logic                 man_ack = 1'b0;
    logic [DW-1:0]        man_dr = '0;
    logic [DW-1:0]        mem [16];

    int n_tests = 0;
    int n_fail  = 0;
    int prio_tab [NC] = '{0, 1, 2, 3};

    // instance 0: strict/TIMEOUT 16, 1: round robin, 2: strict/TIMEOUT 4
    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_arbiter_nch #(
            .SCHED_MODE((g == 1) ? 1'b1 : 1'b0),
            .TIMEOUT   ((g == 2) ? 4 : 16)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .client_rq     (client_rq),
            .client_wr_ni  (client_wr_ni),
            .client_address(client_address),
            .client_dataW  (client_dataW),
            .client_ack    (c_ack[g]),
            .client_dataR  (c_dr[g]),
            .server_rq     (s_rq[g]),
            .server_wr_ni  (s_wr[g]),
            .server_address(s_addr[g]),
            .server_dataW  (s_dw[g]),
            .server_ack    (s_ack[g]),
            .server_dataR  (s_dr[g]),
            .grant_id      (gid[g]),
            .busy          (bsy[g]),
            .timeout_err   (terr[g])
        );
        assign s_ack[g] = auto_ack[g] ? s_rq[g] : man_ack;
        assign s_dr[g]  = auto_ack[g] ? mem[s_addr[g]] : man_dr;
    end

    function automatic int model_sp(input logic [NC-1:0] rq);
        int best = -1;
        int w = 0;
        for (int i = 0; i < NC; i++)
            if (rq[i] && prio_tab[i] > best) begin
                best = prio_tab[i];
                w = i;
            end
        return w;
    endfunction

    function automatic int model_rr(input logic [NC-1:0] rq, input int last);
        for (int k = 1; k <= NC; k++)
            if (rq[(last + k) % NC]) return (last + k) % NC;
        return 0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b0; client_rq = '0; client_wr_ni = '0; client_address = '0;
        client_dataW = '0; man_ack = 1'b0; man_dr = '0; auto_ack = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        next_cycle();
        reset = 1'b0; client_rq = 4'hF; client_wr_ni = 4'hF;
        client_address = 16'($urandom); client_dataW = $urandom; man_ack = 1'b1; man_dr = 8'h5A;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if ({bsy[d], s_rq[d], s_wr[d], terr[d], s_addr[d], s_dw[d], gid[d], c_ack[d], c_dr[d]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got %h, want 0", d,
                         {bsy[d], s_rq[d], s_wr[d], terr[d], s_addr[d], s_dw[d], gid[d], c_ack[d], c_dr[d]});
            end
        end
        next_cycle();
        client_rq = '0; man_ack = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bsy, s_rq} !== 6'b0) begin
            n_fail++;
            $display("FAIL idle_no_rq: busy/server_rq got %b, want 000000", {bsy, s_rq});
        end
    endtask

    task automatic test_strict_priority();
        do_reset();
        auto_ack = 3'b001;
        mem[2] = 8'h3C;
        client_address = 16'h2000;
        client_wr_ni = 4'b0000;
        for (int t = 0; t < 4; t++) begin
            next_cycle(); client_rq = 4'hF; @(negedge clk);
            n_tests++;
            if (bsy[0] !== 1'b0) begin
                n_fail++; $display("FAIL sp_idle t%0d: busy got %b, want 0", t, bsy[0]);
            end
            next_cycle(); @(negedge clk);
            n_tests++;
            if ({bsy[0], gid[0], c_ack[0]} !== {1'b1, 4'd3, 4'b1000}) begin
                n_fail++; $display("FAIL sp_grant t%0d: busy/gid/ack got %h, want %h", t,
                                   {bsy[0], gid[0], c_ack[0]}, {1'b1, 4'd3, 4'b1000});
            end
            n_tests++;
            if (c_dr[0] !== 32'h3C00_0000) begin
                n_fail++; $display("FAIL sp_dataR t%0d: got %h, want 3c000000", t, c_dr[0]);
            end
            next_cycle(); client_rq = 4'b0111; @(negedge clk);
            n_tests++;
            if ({bsy[0], s_rq[0], c_ack[0]} !== 6'b0) begin
                n_fail++; $display("FAIL sp_done t%0d: got %b, want 000000", t, {bsy[0], s_rq[0], c_ack[0]});
            end
        end
    endtask

    task automatic test_read_route();
        do_reset();
        auto_ack = 3'b001;
        mem[9] = 8'hA5;
        next_cycle();
        client_address = {4'($urandom_range(0, 8)), 4'h9, 8'($urandom)};
        client_wr_ni = 4'b1011; client_rq = 4'b0100;
        @(negedge clk);
        next_cycle(); client_rq = 4'b0000; @(negedge clk);
        n_tests++;
        if (c_dr[0] !== 32'h00A5_0000) begin
            n_fail++; $display("FAIL read_route dataR: got %h, want 00a50000", c_dr[0]);
        end
        n_tests++;
        if ({s_addr[0], s_wr[0], c_ack[0]} !== {4'h9, 1'b0, 4'b0100}) begin
            n_fail++; $display("FAIL read_route addr/wr/ack: got %h, want %h",
                               {s_addr[0], s_wr[0], c_ack[0]}, {4'h9, 1'b0, 4'b0100});
        end
        next_cycle(); @(negedge clk);
        n_tests++;
        if ({c_ack[0], c_dr[0]} !== '0) begin
            n_fail++; $display("FAIL read_route done: got %h, want 0", {c_ack[0], c_dr[0]});
        end
    endtask

    task automatic test_round_robin();
        int acks [NC];
        int j;
        do_reset();
        auto_ack = 3'b010;
        for (int i = 0; i < NC; i++) acks[i] = 0;
        for (int k = 0; k < 16; k++) begin
            next_cycle(); client_rq = 4'hF; @(negedge clk);
            if (k % 3 == 1) begin
                j = ((k - 1) / 3) % NC;
                n_tests++;
                if ({bsy[1], gid[1], c_ack[1]} !== {1'b1, 4'(j), 4'(1 << j)}) begin
                    n_fail++; $display("FAIL rr_grant cyc%0d: got %h, want %h", k,
                                       {bsy[1], gid[1], c_ack[1]}, {1'b1, 4'(j), 4'(1 << j)});
                end
            end else begin
                n_tests++;
                if ({bsy[1], c_ack[1]} !== 5'b0) begin
                    n_fail++; $display("FAIL rr_gap cyc%0d: busy/ack got %b, want 00000", k, {bsy[1], c_ack[1]});
                end
            end
            if (k >= 1 && k <= 12)
                for (int i = 0; i < NC; i++) if (c_ack[1][i]) acks[i]++;
        end
        for (int i = 0; i < NC; i++) begin
            n_tests++;
            if (acks[i] != 1) begin
                n_fail++; $display("FAIL rr_fair client%0d: acks in 12 cycles got %0d, want 1", i, acks[i]);
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        man_dr = 8'hFF;
        next_cycle(); client_rq = 4'b0010; @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            next_cycle(); client_rq = 4'b0000; @(negedge clk);
            n_tests++;
            if ({bsy[2], gid[2]} !== {1'b1, 4'd1}) begin
                n_fail++; $display("FAIL wd_busy cyc%0d: got %h, want 11", c, {bsy[2], gid[2]});
            end
            n_tests++;
            if ({c_ack[2], terr[2]} !== {((c == 3) ? 4'b0010 : 4'b0000), (c == 3)}) begin
                n_fail++; $display("FAIL wd_ack cyc%0d: ack/terr got %b, want %b", c, {c_ack[2], terr[2]},
                                   {((c == 3) ? 4'b0010 : 4'b0000), (c == 3)});
            end
            if (c == 3) begin
                n_tests++;
                if (c_dr[2] !== '0) begin
                    n_fail++; $display("FAIL wd_dataR: got %h, want 0", c_dr[2]);
                end
            end
        end
        next_cycle(); @(negedge clk);
        n_tests++;
        if ({bsy[2], s_rq[2], c_ack[2], terr[2]} !== 7'b0) begin
            n_fail++; $display("FAIL wd_done: got %b, want 0000000", {bsy[2], s_rq[2], c_ack[2], terr[2]});
        end
        n_tests++;
        if (bsy[0] !== 1'b1) begin
            n_fail++; $display("FAIL wd_long_timeout_still_busy: got %b, want 1", bsy[0]);
        end
        next_cycle(); @(negedge clk);
        n_tests++;
        if (bsy[2] !== 1'b0) begin
            n_fail++; $display("FAIL wd_idle: busy got %b, want 0", bsy[2]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        next_cycle(); client_rq = 4'b0010; man_ack = 1'b1; @(negedge clk);
        next_cycle(); client_rq = 4'b0000; @(negedge clk);
        n_tests++;
        if ({gid[1], c_ack[1]} !== {4'd1, 4'b0010}) begin
            n_fail++; $display("FAIL mr_first: got %h, want 12", {gid[1], c_ack[1]});
        end
        next_cycle(); man_ack = 1'b0; @(negedge clk);
        next_cycle(); client_rq = 4'b0100; @(negedge clk);
        next_cycle(); client_rq = 4'b0000; @(negedge clk);
        n_tests++;
        if ({bsy[1], s_rq[1], gid[1]} !== {2'b11, 4'd2}) begin
            n_fail++; $display("FAIL mr_grant: got %h, want 32", {bsy[1], s_rq[1], gid[1]});
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({bsy[1], s_rq[1]} !== 2'b00) begin
            n_fail++; $display("FAIL mr_async_drop: busy/server_rq got %b, want 00", {bsy[1], s_rq[1]});
        end
        next_cycle(); reset = 1'b1; client_rq = 4'hF; @(negedge clk);
        next_cycle(); @(negedge clk);
        n_tests++;
        if ({bsy[1], gid[1]} !== {1'b1, 4'd0}) begin
            n_fail++; $display("FAIL mr_rr_restart: got %h, want 10", {bsy[1], gid[1]});
        end
    endtask

    task automatic test_random(input int d, input int n_tx);
        int rr_m;
        int w;
        int lat;
        logic [NC-1:0]    rq;
        logic [NC-1:0]    exp_ack;
        logic [NC*DW-1:0] exp_dr;
        do_reset();
        rr_m = NC - 1;
        for (int t = 0; t < n_tx; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                next_cycle(); client_rq = '0; man_ack = 1'($urandom); @(negedge clk);
                n_tests++;
                if (bsy[d] !== 1'b0) begin
                    n_fail++; $display("FAIL rnd%0d_gap tx%0d: busy got %b, want 0", d, t, bsy[d]);
                end
            end
            rq = 4'($urandom_range(1, 15));
            w = (d == 1) ? model_rr(rq, rr_m) : model_sp(rq);
            lat = $urandom_range(0, 3);
            next_cycle();
            client_rq = rq; client_wr_ni = 4'($urandom); client_address = 16'($urandom);
            client_dataW = $urandom; man_ack = 1'($urandom);
            @(negedge clk);
            n_tests++;
            if (bsy[d] !== 1'b0) begin
                n_fail++; $display("FAIL rnd%0d_idle tx%0d: busy got %b, want 0", d, t, bsy[d]);
            end
            for (int c = 0; c <= lat; c++) begin
                next_cycle();
                client_rq = 4'($urandom); client_wr_ni = 4'($urandom);
                client_address = 16'($urandom); client_dataW = $urandom;
                man_ack = (c == lat); man_dr = 8'($urandom);
                @(negedge clk);
                exp_ack = (c == lat) ? (4'b0001 << w) : 4'b0000;
                exp_dr  = (c == lat) ? (32'(man_dr) << (w * DW)) : 32'h0;
                n_tests++;
                if ({bsy[d], s_rq[d], gid[d]} !== {2'b11, 4'(w)}) begin
                    n_fail++; $display("FAIL rnd%0d_grant tx%0d: got %h, want %h", d, t,
                                       {bsy[d], s_rq[d], gid[d]}, {2'b11, 4'(w)});
                end
                n_tests++;
                if ({s_addr[d], s_wr[d], s_dw[d]} !== {client_address[w*AW +: AW], client_wr_ni[w], client_dataW[w*DW +: DW]}) begin
                    n_fail++; $display("FAIL rnd%0d_mux tx%0d: got %h, want %h", d, t, {s_addr[d], s_wr[d], s_dw[d]},
                                       {client_address[w*AW +: AW], client_wr_ni[w], client_dataW[w*DW +: DW]});
                end
                n_tests++;
                if ({c_ack[d], c_dr[d], terr[d]} !== {exp_ack, exp_dr, 1'b0}) begin
                    n_fail++; $display("FAIL rnd%0d_ack tx%0d: got %h, want %h", d, t,
                                       {c_ack[d], c_dr[d], terr[d]}, {exp_ack, exp_dr, 1'b0});
                end
            end
            if (d == 1) rr_m = w;
            next_cycle(); client_rq = 4'($urandom); man_ack = 1'($urandom); @(negedge clk);
            n_tests++;
            if ({bsy[d], s_rq[d], c_ack[d], c_dr[d]} !== '0) begin
                n_fail++; $display("FAIL rnd%0d_done tx%0d: got %h, want 0", d, t, {bsy[d], s_rq[d], c_ack[d], c_dr[d]});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17 + 1);
        test_reset();
        test_strict_priority();
        test_read_route();
        test_round_robin();
        test_watchdog();
        test_mid_reset();
        test_random(0, 40);
        test_random(1, 40);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_nch.md
Name: bus_arbiter_nch

Overview:
Parametrised N-client bus arbiter. It is the successor to the fixed 4-client arbiter that sits between the client modules and the single ram server. Client buses are flattened vectors, and the client count, priority table and scheduling mode are all parameters. Adds a server-ack watchdog so a silent server can never hang a client. Generates a registered grant and muxes the granted client's rq/address/wr_ni/dataW to the server port.

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 4, address bus width
NUM_CLIENTS, 4, number of client ports (2..16)
PRIO_W, 4, width of one priority field
CLIENT_PRIO, {4'd0,4'd1,4'd2,4'd3}, packed priority table; field i = priority of client i; higher value wins
SCHED_MODE, 1'b0, 0 = strict priority, 1 = round robin
TIMEOUT, 16, server-ack watchdog length in GRANT cycles; 0 disables the watchdog

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
client_rq  input  NUM_CLIENTS  per-client request level
client_wr_ni  input  NUM_CLIENTS  per-client 1 = write, 0 = read
client_address  input  NUM_CLIENTS*ADDR_WIDTH  packed addresses; slice i = client i
client_dataW  input  NUM_CLIENTS*DATA_WIDTH  packed write data
client_ack  output  NUM_CLIENTS  per-client completion strobe
client_dataR  output  NUM_CLIENTS*DATA_WIDTH  packed read data; only granted slice non-zero
server_rq  output  1  request to server
server_wr_ni  output  1  muxed wr_ni
server_address  output  ADDR_WIDTH  muxed address
server_dataW  output  DATA_WIDTH  muxed write data
server_ack  input  1  server completion
server_dataR  input  DATA_WIDTH  server read data
grant_id  output  4  index of granted client, valid while busy
busy  output  1  high in GRANT state
timeout_err  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (reset = 0, async): state = IDLE, grant_id = 0, watchdog count = 0, rr pointer = NUM_CLIENTS-1 (client 0 searched first). Every output reads 0 while reset is low and in IDLE. A reset asserted mid-GRANT drops server_rq immediately.
- FSM IDLE: if any client_rq is set, the winner is registered into grant_id and the state moves to GRANT on the next edge. Otherwise the FSM stays in IDLE.
- Strict priority: the winner is the highest CLIENT_PRIO field among requesters. On equal priority, the lowest index wins.
- Round robin: the winner is the first requester at index rr+1, rr+2, ... modulo NUM_CLIENTS. rr is updated to the winner at the end of each transaction.
- FSM GRANT:
  - server_rq = 1; server_address, wr_ni and dataW track the granted slice combinationally.
  - client_rq is not re-sampled; the grant holds until ack or timeout even if the client drops rq (protocol violation, no error).
  - If server_ack = 1: client_ack[grant_id] = 1 in the same cycle and client_dataR slice = server_dataR. Next state is DONE.
  - Else, if TIMEOUT != 0 and count == TIMEOUT-1: client_ack[grant_id] = 1, that dataR slice = 0, timeout_err = 1 (same cycle). Next state is DONE.
  - Otherwise count increments. count clears on GRANT entry and is wide enough to hold TIMEOUT.
- FSM DONE: exactly 1 cycle with server_rq = 0 and all acks = 0, then IDLE. This gives the client one cycle to drop rq. The just-served client's rq is not sampled in DONE.
- Latency: client_rq high at edge n (in IDLE) gives server_rq high from edge n+1. With a zero-delay server, the minimum transaction is 3 cycles (IDLE, GRANT, DONE).
- At most one client_ack bit is high in any cycle. Non-granted dataR slices are always 0.
- server_ack seen outside GRANT is ignored.
- Requests that arrive simultaneously with a completion are served in the following IDLE.

Test Plan:
- Reset and idle: reset low 2 cycles, no rq -> all outputs 0, server_rq 0; reset high with rq = 4'b0000 -> busy stays 0.
- Strict priority, defaults, zero-delay ram: client_rq = 4'b1111 held; clients drop rq for one cycle after each ack -> grant order 3,3,3,... Client 0 is never granted while client 3 re-requests. Each transaction is 3 cycles.
- Round robin (SCHED_MODE = 1), all four requesting continuously -> grant_id sequence 0,1,2,3,0. Each client gets exactly one ack per 12 cycles.
- Read data routing: client 2 reads addr 4'h9 from a ram preloaded with 8'hA5 -> client_dataR slice 2 = 8'hA5 in the ack cycle; slices 0, 1 and 3 = 0.
- Watchdog: TIMEOUT = 4, server never acks, client 1 requests -> busy for 4 cycles; in the 4th cycle client_ack[1] = 1, timeout_err = 1, dataR slice 1 = 0; then DONE, then IDLE.
- Mid-transaction reset: assert reset 1 cycle into GRANT -> server_rq and busy drop without waiting for a clock. After release, round robin restarts at client 0.
